// File: rtl/div_ctrl.sv
// div_ctrl: glitch-free clock-divider run/stop and load controller; define DIV_CTRL_STATUS_EN for oSTATE/oPERIODS
module div_ctrl #(
  parameter int CNT_W = 26,
  parameter int DEF_HALF = 6250000,
  parameter int MIN_HALF = 2
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iEN,
  input  logic [CNT_W-1:0] iHALF,
  input  logic             iLOAD,
  output logic             oACK,
  output logic             oERR,
  output logic             oPENDING,
  output logic             oSIG,
`ifdef DIV_CTRL_STATUS_EN
  output logic [1:0]       oSTATE,
  output logic [15:0]      oPERIODS,
`endif
  output logic             oTICK
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DRAIN = 2'b10} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, active_q, active_d, shadow_q, shadow_d;
  logic sig_q, sig_d, tick_q, tick_d, ack_q, ack_d, err_q, err_d, pend_q, pend_d;
  logic idle, term, apply, load_ok;
  always_comb begin
    idle = state_q == IDLE;
    term = !idle && cnt_q == active_q - CNT_W'(1);
    apply = pend_q && (idle || term);
    load_ok = iLOAD && iHALF >= CNT_W'(MIN_HALF);
    cnt_d = idle || term ? '0 : cnt_q + CNT_W'(1);
    sig_d = sig_q;
    tick_d = 1'b0;
    state_d = state_q;
    if (idle) state_d = iEN ? RUN : IDLE;
    else if (term) begin
      sig_d = iEN && !sig_q;
      tick_d = iEN || sig_q;
      state_d = iEN ? RUN : IDLE;
    end else state_d = !iEN && sig_q ? DRAIN : RUN;
    active_d = apply ? shadow_q : active_q;
    shadow_d = load_ok ? iHALF : shadow_q;
    pend_d = load_ok || (pend_q && !apply);
    ack_d = apply;
    err_d = iLOAD && !load_ok;
  end
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      cnt_q <= '0;
      active_q <= CNT_W'(DEF_HALF);
      shadow_q <= CNT_W'(DEF_HALF);
      sig_q <= 1'b0;
      tick_q <= 1'b0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      sig_q <= sig_d;
      tick_q <= tick_d;
      ack_q <= ack_d;
      err_q <= err_d;
      pend_q <= pend_d;
    end
  end
  assign oSIG = sig_q;
  assign oTICK = tick_q;
  assign oACK = ack_q;
  assign oERR = err_q;
  assign oPENDING = pend_q;
`ifdef DIV_CTRL_STATUS_EN
  logic [15:0] periods_q, periods_d;
  always_comb periods_d = idle ? 16'd0 : periods_q + 16'(sig_d && !sig_q);
  always_ff @(posedge iCLK) begin
    if (!iRST_N) periods_q <= 16'd0;
    else periods_q <= periods_d;
  end
  assign oSTATE = state_q;
  assign oPERIODS = periods_q;
`endif
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: randomized and directed checks of div_ctrl against a half-period timing model
module tb_div_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, load = 1'b0;
  logic [7:0] half = 8'd0;
  logic oACK, oERR, oPENDING, oSIG, oTICK;
`ifdef DIV_CTRL_STATUS_EN
  logic [1:0] oSTATE;
  logic [15:0] oPERIODS;
`endif
  int n_cmp = 0, n_bad = 0;
  bit m_on, m_sig, m_tick, m_ack, m_err, m_pend;
  int m_left, m_act, m_sh, m_per, m_state;

  div_ctrl #(.CNT_W(8), .DEF_HALF(5), .MIN_HALF(2)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iEN(en), .iHALF(half), .iLOAD(load),
    .oACK(oACK), .oERR(oERR), .oPENDING(oPENDING), .oSIG(oSIG),
`ifdef DIV_CTRL_STATUS_EN
    .oSTATE(oSTATE), .oPERIODS(oPERIODS),
`endif
    .oTICK(oTICK));

  always #5 clk = ~clk;

  task automatic model_edge();
    bit fin, app;
    m_tick = 0; m_ack = 0; m_err = 0;
    if (!rst_n) begin
      m_on = 0; m_left = 0; m_act = 5; m_sh = 5; m_pend = 0; m_sig = 0; m_per = 0; m_state = 0;
      return;
    end
    fin = m_on && m_left == 1;
    app = m_pend && (!m_on || fin);
    if (app) begin m_act = m_sh; m_ack = 1; m_pend = 0; end
    if (!m_on) begin
      m_per = 0;
      if (en) begin m_on = 1; m_left = m_act; end
    end else if (!fin) m_left--;
    else begin
      m_left = m_act;
      if (en) begin
        m_sig = !m_sig; m_tick = 1;
        if (m_sig) m_per = (m_per + 1) % 65536;
      end else begin
        m_tick = m_sig; m_sig = 0; m_on = 0;
      end
    end
    if (load) begin
      if (half >= 2) begin m_sh = half; m_pend = 1; end
      else m_err = 1;
    end
    m_state = !m_on ? 0 : (!en && m_sig ? 2 : 1);
  endtask

  task automatic step(input bit e, input bit l, input int h, input bit r);
    en = e; load = l; half = 8'(h); rst_n = r;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 9, 0);
      n_cmp++;
      if ({oSIG, oTICK, oACK, oERR, oPENDING} !== 5'b0) begin
        n_bad++; $display("FAIL reset outputs: got %b want 00000", {oSIG, oTICK, oACK, oERR, oPENDING});
      end
    end
  endtask

  task automatic test_run();
    int rise = -1, last = -1;
    for (int i = 1; i <= 40; i++) begin
      step(1, 0, 0, 1);
      n_cmp++;
      if ({oSIG, oTICK, oACK, oERR, oPENDING} !== {m_sig, m_tick, m_ack, m_err, m_pend}) begin
        n_bad++; $display("FAIL run cyc %0d: got %b want %b", i, {oSIG, oTICK, oACK, oERR, oPENDING}, {m_sig, m_tick, m_ack, m_err, m_pend});
      end
      if (rise < 0 && oSIG) rise = i;
      if (oTICK) begin
        if (last > 0) begin
          n_cmp++;
          if (i - last !== 5) begin n_bad++; $display("FAIL run gap: got %0d want 5", i - last); end
        end
        last = i;
      end
    end
    n_cmp++;
    if (rise !== 6) begin n_bad++; $display("FAIL first rise: got cycle %0d want 6", rise); end
  endtask

  task automatic test_load();
    int last = -1, acks = 0;
    for (int i = 0; i < 40 && !(m_on && !m_sig && m_left == 4); i++) step(1, 0, 0, 1);
    step(1, 1, 3, 1);
    n_cmp++;
    if (oPENDING !== 1'b1 || oACK !== 1'b0) begin n_bad++; $display("FAIL load pending: got pend=%b ack=%b want 1 0", oPENDING, oACK); end
    for (int i = 1; i <= 30; i++) begin
      step(1, 0, 0, 1);
      n_cmp++;
      if ({oSIG, oTICK, oACK, oERR, oPENDING} !== {m_sig, m_tick, m_ack, m_err, m_pend}) begin
        n_bad++; $display("FAIL load cyc %0d: got %b want %b", i, {oSIG, oTICK, oACK, oERR, oPENDING}, {m_sig, m_tick, m_ack, m_err, m_pend});
      end
      if (oTICK) begin
        if (acks > 0) begin
          n_cmp++;
          if (i - last !== 3) begin n_bad++; $display("FAIL load gap: got %0d want 3", i - last); end
        end
        last = i;
      end
      if (oACK) acks++;
    end
    n_cmp++;
    if (acks !== 1 || oPENDING !== 1'b0) begin n_bad++; $display("FAIL load ack count: got %0d pend=%b want 1 0", acks, oPENDING); end
  endtask

  task automatic test_err();
    int last = -1;
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(1, 0, 0, 1); step(1, 0, 0, 1);
    step(1, 1, 1, 1);
    n_cmp++;
    if (oERR !== 1'b1 || oPENDING !== 1'b0 || oACK !== 1'b0) begin
      n_bad++; $display("FAIL err pulse: got err=%b pend=%b ack=%b want 1 0 0", oERR, oPENDING, oACK);
    end
    for (int i = 1; i <= 30; i++) begin
      step(1, 0, 0, 1);
      n_cmp++;
      if ({oSIG, oTICK, oACK, oERR, oPENDING} !== {m_sig, m_tick, m_ack, m_err, m_pend}) begin
        n_bad++; $display("FAIL err cyc %0d: got %b want %b", i, {oSIG, oTICK, oACK, oERR, oPENDING}, {m_sig, m_tick, m_ack, m_err, m_pend});
      end
      if (oTICK) begin
        if (last > 0) begin
          n_cmp++;
          if (i - last !== 5) begin n_bad++; $display("FAIL err gap: got %0d want 5", i - last); end
        end
        last = i;
      end
    end
  endtask

  task automatic test_stop();
    int n = 0;
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    for (int i = 0; i < 40 && !(m_on && m_sig && m_left == 4); i++) step(1, 0, 0, 1);
    step(0, 0, 0, 1);
`ifdef DIV_CTRL_STATUS_EN
    n_cmp++;
    if (oSTATE !== 2'b10) begin n_bad++; $display("FAIL drain state: got %b want 10", oSTATE); end
`endif
    for (int i = 0; i < 10 && oSIG; i++) begin
      n++;
      step(0, 0, 0, 1);
      n_cmp++;
      if ({oSIG, oTICK, oACK, oERR, oPENDING} !== {m_sig, m_tick, m_ack, m_err, m_pend}) begin
        n_bad++; $display("FAIL drain cyc %0d: got %b want %b", i, {oSIG, oTICK, oACK, oERR, oPENDING}, {m_sig, m_tick, m_ack, m_err, m_pend});
      end
    end
    n_cmp++;
    if (n !== 3 || oTICK !== 1'b1) begin n_bad++; $display("FAIL drain length: got %0d tick=%b want 3 1", n, oTICK); end
    step(0, 0, 0, 1); step(0, 0, 0, 1);
`ifdef DIV_CTRL_STATUS_EN
    n_cmp++;
    if (oSTATE !== 2'b00 || oPERIODS !== 16'd0) begin n_bad++; $display("FAIL idle status: got %b %0d want 00 0", oSTATE, oPERIODS); end
`endif
    for (int i = 0; i < 60 && !(m_on && !m_sig && m_left == 3 && m_per >= 1); i++) step(1, 0, 0, 1);
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 0, 1);
      n_cmp++;
      if (oSIG !== 1'b0 || oTICK !== 1'b0) begin n_bad++; $display("FAIL low stop cyc %0d: got sig=%b tick=%b want 0 0", i, oSIG, oTICK); end
    end
    step(1, 0, 0, 1);
    for (int i = 1; i <= 6; i++) begin
      step(1, 0, 0, 1);
      n_cmp++;
      if (oSIG !== (i == 5 || i == 6)) begin n_bad++; $display("FAIL restart cyc %0d: got sig=%b", i, oSIG); end
    end
  endtask

  task automatic test_back_to_back();
    int last = 0, acks = 0;
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(1, 0, 0, 1);
    step(1, 1, 7, 1);
    for (int i = 0; i < 40 && !(m_on && m_pend && m_left == 1); i++) step(1, 0, 0, 1);
    step(1, 1, 4, 1);
    n_cmp++;
    if (oACK !== 1'b1 || oPENDING !== 1'b1) begin n_bad++; $display("FAIL b2b first ack: got ack=%b pend=%b want 1 1", oACK, oPENDING); end
    for (int i = 1; i <= 40; i++) begin
      step(1, 0, 0, 1);
      n_cmp++;
      if ({oSIG, oTICK, oACK, oERR, oPENDING} !== {m_sig, m_tick, m_ack, m_err, m_pend}) begin
        n_bad++; $display("FAIL b2b cyc %0d: got %b want %b", i, {oSIG, oTICK, oACK, oERR, oPENDING}, {m_sig, m_tick, m_ack, m_err, m_pend});
      end
      if (oTICK) begin
        n_cmp++;
        if (i - last !== (acks > 0 ? 4 : 7)) begin n_bad++; $display("FAIL b2b gap: got %0d want %0d", i - last, acks > 0 ? 4 : 7); end
        last = i;
      end
      if (oACK) acks++;
    end
    n_cmp++;
    if (acks !== 1) begin n_bad++; $display("FAIL b2b second ack count: got %0d want 1", acks); end
  endtask

  task automatic test_reset_mid();
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    for (int i = 0; i < 40 && !(m_on && m_sig && m_left == 3); i++) step(1, 0, 0, 1);
    step(1, 1, 9, 1);
    n_cmp++;
    if (oSIG !== 1'b1 || oPENDING !== 1'b1) begin n_bad++; $display("FAIL pre-reset: got sig=%b pend=%b want 1 1", oSIG, oPENDING); end
    step(1, 0, 0, 0);
    n_cmp++;
    if ({oSIG, oTICK, oACK, oERR, oPENDING} !== 5'b0) begin n_bad++; $display("FAIL mid reset: got %b want 00000", {oSIG, oTICK, oACK, oERR, oPENDING}); end
    test_run();
  endtask

  task automatic test_random();
    bit e = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) e = !e;
      step(e, $urandom_range(0, 7) == 0, int'($urandom_range(0, 10)), $urandom_range(0, 199) != 0);
      n_cmp++;
      if ({oSIG, oTICK, oACK, oERR, oPENDING} !== {m_sig, m_tick, m_ack, m_err, m_pend}) begin
        n_bad++; $display("FAIL random cyc %0d: got %b want %b", i, {oSIG, oTICK, oACK, oERR, oPENDING}, {m_sig, m_tick, m_ack, m_err, m_pend});
      end
`ifdef DIV_CTRL_STATUS_EN
      n_cmp++;
      if (oSTATE !== 2'(m_state) || oPERIODS !== 16'(m_per)) begin
        n_bad++; $display("FAIL random status cyc %0d: got %b %0d want %0d %0d", i, oSTATE, oPERIODS, m_state, m_per);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_load();
    test_err();
    test_stop();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
